// File: rtl/snes_ctrl_pkg.sv
// Shared constants and button-to-serial-word mapping for the SNES controller port.
package snes_ctrl_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned BTN_W    = 12;
  localparam int unsigned NUM_PADS = 4;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

  // Bit positions inside the 12-bit JOYn button vectors
  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_X      = 6;
  localparam int unsigned BTN_Y      = 7;
  localparam int unsigned BTN_L      = 8;
  localparam int unsigned BTN_R      = 9;
  localparam int unsigned BTN_SELECT = 10;
  localparam int unsigned BTN_START  = 11;

  // Serial order as the console reads it, MSB first, followed by a zero ID nibble
  function automatic logic [WORD_W-1:0] pad_word(input logic [BTN_W-1:0] joy);
    return {joy[BTN_B], joy[BTN_Y], joy[BTN_SELECT], joy[BTN_START],
            joy[BTN_UP], joy[BTN_DOWN], joy[BTN_LEFT], joy[BTN_RIGHT],
            joy[BTN_A], joy[BTN_X], joy[BTN_L], joy[BTN_R], 4'b0000};
  endfunction

endpackage

// File: rtl/snes_pad_shifter.sv
// One pad's parallel-load / shift-left register; serial output is the MSB.
module snes_pad_shifter
  import snes_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_val,
  input  logic              shift,
  output logic              ser_o
);

  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] data_d;

  // Load has priority over shift
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_val;
    end else if (shift) begin
      data_d = {data_q[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '1;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_o = data_q[WORD_W-1];

endmodule

// File: rtl/snes_multitap.sv
// Four-pad SNES multitap: pair-selected serial readout with per-pair bit counters.
module snes_multitap
  import snes_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PORT_LATCH,
  input  logic             PORT_CLK,
  input  logic             PORT_SEL,
  input  logic [BTN_W-1:0] JOY1,
  input  logic [BTN_W-1:0] JOY2,
  input  logic [BTN_W-1:0] JOY3,
  input  logic [BTN_W-1:0] JOY4,
  input  logic [3:0]       PAD_CONNECTED,
  input  logic             MULTITAP_EN,
  output logic [1:0]       PORT_DO,
  output logic [1:0]       READ_DONE
);

  logic [1:0]       rst_sync_q;
  logic [1:0]       rst_sync_d;
  logic             rst_n;
  logic             port_clk_q;
  logic             port_clk_d;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q;
  logic [CNT_W-1:0] cnt_b_d;
  logic [1:0]       port_do_q;
  logic [1:0]       port_do_d;
  logic [1:0]       read_done_q;
  logic [1:0]       read_done_d;

  logic              clk_step;
  logic              shift_a;
  logic              shift_b;
  logic              done_a;
  logic              done_b;
  logic              line_a1;
  logic              line_a2;
  logic              line_b3;
  logic              line_b4;
  logic [NUM_PADS-1:0] pad_shift;
  logic [NUM_PADS-1:0] pad_msb;
  logic [BTN_W-1:0]    joy      [NUM_PADS];
  logic [WORD_W-1:0]   load_val [NUM_PADS];

  // Reset asserts immediately, releases two CLK edges later
  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  // Latch dominates: no shifting or counting while it is high
  assign port_clk_d = PORT_CLK;
  assign clk_step   = PORT_CLK & ~port_clk_q & ~PORT_LATCH;
  assign shift_a    = clk_step & (~MULTITAP_EN | PORT_SEL);
  assign shift_b    = clk_step & MULTITAP_EN & ~PORT_SEL;
  assign pad_shift  = {shift_b, shift_b, shift_a & MULTITAP_EN, shift_a};

  // Shift registers hold the active-low word; absent pads read as released
  always_comb begin
    joy[0] = JOY1;
    joy[1] = JOY2;
    joy[2] = JOY3;
    joy[3] = JOY4;
    for (int n = 0; n < NUM_PADS; n++) begin
      load_val[n] = PAD_CONNECTED[n] ? ~pad_word(joy[n]) : '1;
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    snes_pad_shifter u_shifter (
      .clk      (CLK),
      .rst_n    (rst_n),
      .load     (PORT_LATCH),
      .load_val (load_val[g]),
      .shift    (pad_shift[g]),
      .ser_o    (pad_msb[g])
    );
  end

  assign done_a = (cnt_a_q == CNT_FULL);
  assign done_b = (cnt_b_q == CNT_FULL);

  // Per-pair bit counters, saturating once the full word has been read
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (PORT_LATCH) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (shift_a && !done_a) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (shift_b && !done_b) cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  assign read_done_d = {cnt_b_d == CNT_FULL, cnt_a_d == CNT_FULL};

  // Data lines go low once a pair has delivered all of its bits
  assign line_a1 = pad_msb[0] & ~done_a;
  assign line_a2 = pad_msb[1] & ~done_a;
  assign line_b3 = pad_msb[2] & ~done_b;
  assign line_b4 = pad_msb[3] & ~done_b;

  // D1 low during latch is the multitap presence signature
  always_comb begin
    port_do_d = {1'b1, line_a1};
    if (MULTITAP_EN) begin
      port_do_d[0] = PORT_SEL ? line_a1 : line_b3;
      port_do_d[1] = PORT_LATCH ? 1'b0 : (PORT_SEL ? line_a2 : line_b4);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      port_clk_q  <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      port_do_q   <= 2'b11;
      read_done_q <= 2'b00;
    end else begin
      port_clk_q  <= port_clk_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      port_do_q   <= port_do_d;
      read_done_q <= read_done_d;
    end
  end

  assign PORT_DO   = port_do_q;
  assign READ_DONE = read_done_q;

endmodule

// File: tb/tb_snes_multitap.sv
// Bench for snes_multitap: directed table, multi-cycle corner sequences, random vs. reference model.
module tb_snes_multitap;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PORT_LATCH;
  logic        PORT_CLK;
  logic        PORT_SEL;
  logic [11:0] JOY1, JOY2, JOY3, JOY4;
  logic [3:0]  PAD_CONNECTED;
  logic        MULTITAP_EN;
  logic [1:0]  PORT_DO;
  logic [1:0]  READ_DONE;

  snes_multitap dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .PORT_LATCH    (PORT_LATCH),
    .PORT_CLK      (PORT_CLK),
    .PORT_SEL      (PORT_SEL),
    .JOY1          (JOY1),
    .JOY2          (JOY2),
    .JOY3          (JOY3),
    .JOY4          (JOY4),
    .PAD_CONNECTED (PAD_CONNECTED),
    .MULTITAP_EN   (MULTITAP_EN),
    .PORT_DO       (PORT_DO),
    .READ_DONE     (READ_DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: latched buttons per pad, read index per pad, bits-read count per pair
  int          rd_map [12] = '{5, 7, 10, 11, 3, 2, 1, 0, 4, 6, 8, 9};
  logic [11:0] m_joy  [4];
  bit          m_conn [4];
  int          m_pos  [4];
  int          m_cnt  [2];
  bit          m_prev;
  int          hold;

  typedef struct {
    bit       latch;
    bit       pclk;
    bit       sel;
    bit       mt;
    logic [1:0] exp_do;
    logic [1:0] exp_done;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_joy[n]  = '0;
      m_conn[n] = 1'b0;
      m_pos[n]  = 0;
    end
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_prev   = 1'b0;
  endtask

  function automatic bit line_bit(input int n, input int pr);
    if (m_cnt[pr] >= 16) return 1'b0;
    if (m_pos[n] >= 16) return 1'b0;
    if (!m_conn[n] || m_pos[n] >= 12) return 1'b1;
    return ~m_joy[n][rd_map[m_pos[n]]];
  endfunction

  function automatic int inc16(input int v);
    return (v >= 16) ? 16 : v + 1;
  endfunction

  task automatic step(input bit latch, input bit pclk);
    logic [1:0]  exp_do;
    logic [1:0]  exp_done;
    logic [11:0] cur [4];
    bit          a1, a2, b3, b4, rise;
    PORT_LATCH = latch;
    PORT_CLK   = pclk;
    @(posedge CLK);
    cur[0] = JOY1; cur[1] = JOY2; cur[2] = JOY3; cur[3] = JOY4;
    if (hold > 0) begin
      exp_do   = 2'b11;
      exp_done = 2'b00;
      hold--;
    end else begin
      a1 = line_bit(0, 0);
      a2 = line_bit(1, 0);
      b3 = line_bit(2, 1);
      b4 = line_bit(3, 1);
      if (MULTITAP_EN) begin
        exp_do[0] = PORT_SEL ? a1 : b3;
        exp_do[1] = latch ? 1'b0 : (PORT_SEL ? a2 : b4);
      end else begin
        exp_do = {1'b1, a1};
      end
      rise   = pclk && !m_prev;
      m_prev = pclk;
      if (latch) begin
        for (int n = 0; n < 4; n++) begin
          m_joy[n]  = cur[n];
          m_conn[n] = PAD_CONNECTED[n];
          m_pos[n]  = 0;
        end
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end else if (rise) begin
        if (!MULTITAP_EN || PORT_SEL) begin
          m_cnt[0] = inc16(m_cnt[0]);
          m_pos[0] = inc16(m_pos[0]);
          if (MULTITAP_EN) m_pos[1] = inc16(m_pos[1]);
        end else begin
          m_cnt[1] = inc16(m_cnt[1]);
          m_pos[2] = inc16(m_pos[2]);
          m_pos[3] = inc16(m_pos[3]);
        end
      end
      exp_done = {m_cnt[1] >= 16, m_cnt[0] >= 16};
    end
    #1;
    check("port_do", PORT_DO, exp_do);
    check("read_done", READ_DONE, exp_done);
  endtask

  task automatic pclk_pulse();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic latch_then_idle();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Called just after a sampled edge; reset is released well before the next edge
  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    check("reset_do", PORT_DO, 2'b11);
    check("reset_done", READ_DONE, 2'b00);
    model_reset();
    #2;
    RESET_N = 1'b1;
    hold = 2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pl;
    RESET_N = 1'b1;
    PORT_LATCH = 1'b0; PORT_CLK = 1'b0; PORT_SEL = 1'b1; MULTITAP_EN = 1'b1;
    JOY1 = '0; JOY2 = '0; JOY3 = '0; JOY4 = '0;
    PAD_CONNECTED = 4'hF;
    hold = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Directed table: JOY1 = B only, all pads present
    JOY1 = 12'h020;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00};
    for (int i = 0; i < 11; i++) begin
      PORT_SEL    = tbl[i].sel;
      MULTITAP_EN = tbl[i].mt;
      step(tbl[i].latch, tbl[i].pclk);
      check("tbl_do", PORT_DO, tbl[i].exp_do);
      check("tbl_done", READ_DONE, tbl[i].exp_done);
    end
    step(1'b0, 1'b0);

    // Full pad-1 read with B pressed: 0, fifteen 1s, then 0s
    PORT_SEL = 1'b1;
    latch_then_idle();
    check("b_first_bit", {1'b0, PORT_DO[0]}, 2'b00);
    for (int k = 1; k <= 18; k++) begin
      pclk_pulse();
      check("b_stream", {1'b0, PORT_DO[0]}, {1'b0, (k < 16) ? 1'b1 : 1'b0});
      check("b_done", {1'b0, READ_DONE[0]}, {1'b0, (k >= 16) ? 1'b1 : 1'b0});
    end

    // Single mode keeps D1 high, latched or not
    MULTITAP_EN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(k < 2, 1'(k));
      check("single_d1", {1'b0, PORT_DO[1]}, 2'b01);
    end
    step(1'b0, 1'b0);
    MULTITAP_EN = 1'b1;

    // Pair switch mid-read: pads keep their own read positions
    JOY1 = 12'h010;
    JOY3 = 12'h001;
    PORT_SEL = 1'b1;
    latch_then_idle();
    repeat (8) pclk_pulse();
    PORT_SEL = 1'b0;
    step(1'b0, 1'b0);
    check("sel_b_first", {1'b0, PORT_DO[0]}, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      pclk_pulse();
      check("right_pos", {1'b0, PORT_DO[0]}, {1'b0, (k == 7) ? 1'b0 : 1'b1});
    end
    PORT_SEL = 1'b1;
    step(1'b0, 1'b0);
    check("resume_a_bit8", {1'b0, PORT_DO[0]}, 2'b00);

    // Missing pad 3 reads released for 16 bits then 0
    PAD_CONNECTED = 4'b1011;
    JOY3 = 12'hFFF;
    PORT_SEL = 1'b0;
    latch_then_idle();
    check("nopad_first", {1'b0, PORT_DO[0]}, 2'b01);
    for (int k = 1; k <= 17; k++) begin
      pclk_pulse();
      check("nopad_stream", {1'b0, PORT_DO[0]}, {1'b0, (k < 16) ? 1'b1 : 1'b0});
    end
    PAD_CONNECTED = 4'hF;

    // Clock edges during latch are ignored
    JOY1 = 12'h020;
    PORT_SEL = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("latch_edges_done", READ_DONE, 2'b00);
    step(1'b0, 1'b0);
    check("latch_edges_bit15", {1'b0, PORT_DO[0]}, 2'b00);
    repeat (15) pclk_pulse();
    check("latch_edges_15", READ_DONE, 2'b00);
    pclk_pulse();
    check("latch_edges_16", READ_DONE, 2'b01);

    // Reset mid-read aborts; data returns only after a fresh latch
    latch_then_idle();
    repeat (5) pclk_pulse();
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_reset_idle", PORT_DO, 2'b11);
    latch_then_idle();
    check("post_reset_bit15", {1'b0, PORT_DO[0]}, 2'b00);

    // Random traffic against the model
    pl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) PORT_SEL = ~PORT_SEL;
      if ($urandom_range(0, 79) == 0) MULTITAP_EN = ~MULTITAP_EN;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: JOY1 = 12'($urandom);
          1: JOY2 = 12'($urandom);
          2: JOY3 = 12'($urandom);
          default: JOY4 = 12'($urandom);
        endcase
      end
      if ($urandom_range(0, 199) == 0) PAD_CONNECTED = 4'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      if ($urandom_range(0, 9) < 7) pl = ~pl;
      step($urandom_range(0, 59) == 0, pl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
